uart_autobaud: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_line_sync.sv | 47 ++++
 rtl/uart_autobaud.sv | 138 +++++++++++++
 tb/tb_uart_autobaud.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART auto-baud controller
// Contents: FSM state encoding, sync-character constants, bit-span shift.
package uart_pkg;

   localparam int AB_IDLE   = 0;
   localparam int AB_ARM    = 1;
   localparam int AB_MEAS   = 2;
   localparam int AB_CHECK  = 3;
   localparam int AB_LOCKED = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'(AB_IDLE),
      ST_ARM    = 3'(AB_ARM),
      ST_MEAS   = 3'(AB_MEAS),
      ST_CHECK  = 3'(AB_CHECK),
      ST_LOCKED = 3'(AB_LOCKED)
   } ab_state_t;

   // 0x55 in 8n1 gives falling edges at bit times 0,2,4,6,8
   localparam logic [7:0] AB_SYNC_CHAR = 8'h55;
   localparam int AB_EDGES = 5;
   // four intervals span 8 bit times
   localparam int AB_BIT_SPAN_SHIFT = 3;

endpackage

// File: rtl/uart_line_sync.sv
// rtl/uart_line_sync.sv - line synchronizer, optional deglitch and falling-edge detect
// Ports: clk, rst_n (async active-low), in (raw line), s (conditioned line), fe (falling edge of s).
// Macro UART_AUTOBAUD_DEGLITCH_EN adds a 3-sample majority filter (+1 cycle latency).
module uart_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic s,
   output logic fe
);

   logic sy1, sy2, s_prev;

`ifdef UART_AUTOBAUD_DEGLITCH_EN
   logic d1, d2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1 <= 1'b1;
         d2 <= 1'b1;
      end else begin
         d1 <= sy2;
         d2 <= d1;
      end
   end

   // a single-cycle excursion of sy2 can never win the vote
   assign s = (sy2 & d1) | (sy2 & d2) | (d1 & d2);
`else
   assign s = sy2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sy1    <= 1'b1;
         sy2    <= 1'b1;
         s_prev <= 1'b1;
      end else begin
         sy1    <= in;
         sy2    <= sy1;
         s_prev <= s;
      end
   end

   assign fe = s_prev & ~s;

endmodule

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - measures a 0x55 sync character and drives the receiver oversampling factor
// Ports: clk, rst_n (async active-low), in (raw line), relock (re-measure request),
//        o (oversampling factor), locked (o valid), upd (o updated pulse), err (rejected pulse).
// Macro UART_AUTOBAUD_DEGLITCH_EN enables the majority filter in uart_line_sync.
module uart_autobaud
   import uart_pkg::*;
#(
   parameter int ow       = 5,
   parameter int OMIN     = 4,
   parameter int CW       = 10,
   parameter int IDLE_MIN = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in,
   input  logic          relock,
   output logic [ow-1:0] o,
   output logic          locked,
   output logic          upd,
   output logic          err
);

   localparam int HW = $clog2(IDLE_MIN + 1);
   localparam logic [CW+2:0] C_MIN = (CW+3)'(OMIN);
   localparam logic [CW+2:0] C_MAX = (CW+3)'(2**ow - 1);

   logic            s, fe;
   ab_state_t       st;
   logic [HW-1:0]   hr;
   logic [CW-1:0]   ic;
   logic [CW+1:0]   sum;
   logic [2:0]      k;
   logic [CW-1:0]   iv [4];
   logic [CW+2:0]   cand;
   logic            tol_ok, range_ok;

   uart_line_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .s     (s),
      .fe    (fe)
   );

   // extra headroom bit: the rounding offset can carry past the sum width
   assign cand     = ({1'b0, sum} + (CW+3)'(4)) >> AB_BIT_SPAN_SHIFT;
   assign range_ok = (cand >= C_MIN) && (cand <= C_MAX);

   always_comb begin
      logic [CW-1:0] diff;
      tol_ok = 1'b1;
      diff   = '0;
      for (int j = 1; j < 4; j++) begin
         diff = (iv[j] >= iv[0]) ? (iv[j] - iv[0]) : (iv[0] - iv[j]);
         if (diff > (iv[0] >> 2))
            tol_ok = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= ST_IDLE;
         o      <= ow'(OMIN);
         locked <= 1'b0;
         upd    <= 1'b0;
         err    <= 1'b0;
         hr     <= '0;
         ic     <= '0;
         sum    <= '0;
         k      <= '0;
         for (int j = 0; j < 4; j++)
            iv[j] <= '0;
      end else begin
         upd <= 1'b0;
         err <= 1'b0;
         if (relock) begin
            // discards any partial measurement silently; wins over accept in CHECK
            st     <= ST_IDLE;
            locked <= 1'b0;
            hr     <= '0;
         end else begin
            case (st)
               ST_IDLE: begin
                  if (s) begin
                     if (hr == HW'(IDLE_MIN - 1)) begin
                        hr <= '0;
                        st <= ST_ARM;
                     end else begin
                        hr <= hr + 1'b1;
                     end
                  end else begin
                     hr <= '0;
                  end
               end
               ST_ARM: begin
                  if (fe) begin
                     st  <= ST_MEAS;
                     k   <= 3'd1;
                     ic  <= CW'(1);
                     sum <= '0;
                  end
               end
               ST_MEAS: begin
                  if (fe) begin
                     iv[2'(k - 3'd1)] <= ic;
                     sum <= sum + {2'b00, ic};
                     ic  <= CW'(1);
                     k   <= k + 3'd1;
                     if (k == 3'(AB_EDGES - 1))
                        st <= ST_CHECK;
                  end else if (ic == '1) begin
                     err <= 1'b1;
                     hr  <= '0;
                     st  <= ST_IDLE;
                  end else begin
                     ic <= ic + 1'b1;
                  end
               end
               ST_CHECK: begin
                  if (tol_ok && range_ok) begin
                     o      <= cand[ow-1:0];
                     locked <= 1'b1;
                     upd    <= 1'b1;
                     st     <= ST_LOCKED;
                  end else begin
                     err <= 1'b1;
                     hr  <= '0;
                     st  <= ST_IDLE;
                  end
               end
               ST_LOCKED: ;
               default: st <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb/tb_uart_autobaud.sv - randomized self-checking bench for uart_autobaud
module tb_uart_autobaud;
   import uart_pkg::*;

   localparam int OMIN = 4;
   localparam int OMAX = 31;
`ifdef UART_AUTOBAUD_DEGLITCH_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif

   logic       clk, rst_n, in, relock;
   logic [4:0] o;
   logic       locked, upd, err;

   int comp = 0;
   int fails = 0;
   int cyc = 0;
   int last_fall = 0;
   int last_upd_cyc = 0;
   int upd_cnt = 0, err_cnt = 0;
   int lk_cnt = 0, oe_cnt = 0;
   int watch_on = 0, watch_base = 0, watch_val = 0;
   int exp_o = OMIN;

   uart_autobaud dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in),
      .relock (relock),
      .o      (o),
      .locked (locked),
      .upd    (upd),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (watch_on != 0 && upd_cnt == watch_base && !upd) begin
         if (locked) lk_cnt++;
         if (int'(o) != watch_val) oe_cnt++;
      end
      if (upd) begin
         upd_cnt++;
         last_upd_cyc = cyc;
      end
      if (err) err_cnt++;
   end

   task automatic seg(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (lvl == 1'b0 && in == 1'b1) last_fall = cyc;
         in = lvl;
      end
   endtask

   task automatic send_byte(input logic [7:0] data, input int p);
      seg(1'b0, p);
      for (int i = 0; i < 8; i++) seg(data[i], p);
      seg(1'b1, p);
   endtask

   task automatic send_ivs(input int a, input int b, input int c, input int d, input int tail);
      int v[4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         seg(1'b0, v[i] / 2);
         seg(1'b1, v[i] - v[i] / 2);
      end
      seg(1'b0, tail);
      seg(1'b1, 40);
   endtask

   // reference rules: four falling-edge intervals, tolerance vs the first, rounded mean per bit
   task automatic model(input int a, input int b, input int c, input int d,
                        output bit ok, output int cand);
      int tol;
      tol  = a / 4;
      ok   = 1'b1;
      if ((b > a ? b - a : a - b) > tol) ok = 1'b0;
      if ((c > a ? c - a : a - c) > tol) ok = 1'b0;
      if ((d > a ? d - a : a - d) > tol) ok = 1'b0;
      cand = (a + b + c + d + 4) / 8;
      if (cand < OMIN || cand > OMAX) ok = 1'b0;
   endtask

   task automatic do_relock();
      @(negedge clk);
      relock = 1'b1;
      @(negedge clk);
      relock = 1'b0;
      comp++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL relock_clears_locked: got %0b expected 0", locked);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in = 1'b1; relock = 1'b0;
      repeat (3) @(negedge clk);
      comp++;
      if (o !== 5'(OMIN) || locked !== 1'b0 || upd !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_values: o=%0d locked=%0b upd=%0b err=%0b expected o=%0d 0 0 0",
                  o, locked, upd, err, OMIN);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_timeout();
      int ub, eb;
      ub = upd_cnt; eb = err_cnt;
      seg(1'b1, 40);
      send_byte(8'h00, 8);
      seg(1'b1, 1100);
      comp++;
      if (err_cnt - eb != 1) begin
         fails++;
         $display("FAIL timeout_err: got %0d pulses expected 1", err_cnt - eb);
      end
      comp++;
      if (upd_cnt - ub != 0 || o !== 5'(OMIN) || locked !== 1'b0) begin
         fails++;
         $display("FAIL timeout_state: upd=%0d o=%0d locked=%0b expected 0 %0d 0",
                  upd_cnt - ub, o, locked, OMIN);
      end
   endtask

   task automatic lock_at(input string nm, input int p);
      int ub, eb;
      ub = upd_cnt; eb = err_cnt;
      seg(1'b1, 40);
      send_byte(AB_SYNC_CHAR, p);
      seg(1'b1, 40);
      exp_o = p;
      comp++;
      if (upd_cnt - ub != 1 || err_cnt - eb != 0) begin
         fails++;
         $display("FAIL %s_pulses: upd=%0d err=%0d expected 1 0", nm, upd_cnt - ub, err_cnt - eb);
      end
      comp++;
      if (int'(o) != p || locked !== 1'b1) begin
         fails++;
         $display("FAIL %s_lock: o=%0d locked=%0b expected %0d 1", nm, o, locked, p);
      end
      comp++;
      if (last_upd_cyc != last_fall + LAT) begin
         fails++;
         $display("FAIL %s_latency: upd at %0d expected %0d", nm, last_upd_cyc, last_fall + LAT);
      end
   endtask

   task automatic test_lock8();
      lock_at("lock8", 8);
   endtask

   task automatic test_jitter13();
      int ub;
      do_relock();
      ub = upd_cnt;
      seg(1'b1, 40);
      send_ivs(26, 28, 26, 26, 13);
      exp_o = 13;
      comp++;
      if (upd_cnt - ub != 1 || o !== 5'd13 || locked !== 1'b1) begin
         fails++;
         $display("FAIL jitter13: upd=%0d o=%0d locked=%0b expected 1 13 1", upd_cnt - ub, o, locked);
      end
   endtask

   task automatic test_range();
      int ub, eb;
      do_relock();
      ub = upd_cnt; eb = err_cnt;
      seg(1'b1, 40);
      send_byte(AB_SYNC_CHAR, 2);
      seg(1'b1, 40);
      comp++;
      if (err_cnt - eb != 1 || upd_cnt - ub != 0 || int'(o) != exp_o || locked !== 1'b0) begin
         fails++;
         $display("FAIL range_low: err=%0d upd=%0d o=%0d locked=%0b expected 1 0 %0d 0",
                  err_cnt - eb, upd_cnt - ub, o, locked, exp_o);
      end
      eb = err_cnt;
      send_byte(AB_SYNC_CHAR, 40);
      seg(1'b1, 40);
      comp++;
      if (err_cnt - eb != 1 || upd_cnt - ub != 0 || int'(o) != exp_o || locked !== 1'b0) begin
         fails++;
         $display("FAIL range_high: err=%0d upd=%0d o=%0d locked=%0b expected 1 0 %0d 0",
                  err_cnt - eb, upd_cnt - ub, o, locked, exp_o);
      end
   endtask

   task automatic test_relock();
      int lb, ob;
      do_relock();
      lock_at("relock_first", 8);
      do_relock();
      lb = lk_cnt; ob = oe_cnt;
      watch_val = 8; watch_base = upd_cnt; watch_on = 1;
      lock_at("relock_second", 12);
      watch_on = 0;
      comp++;
      if (lk_cnt - lb != 0 || oe_cnt - ob != 0) begin
         fails++;
         $display("FAIL relock_hold: locked-high cycles=%0d o-changed cycles=%0d expected 0 0",
                  lk_cnt - lb, oe_cnt - ob);
      end
   endtask

   task automatic test_glitch();
      int ub, eb, eu, ex_o, ex_l;
      do_relock();
      ub = upd_cnt; eb = err_cnt;
      seg(1'b1, 20);
      seg(1'b0, 1);
      seg(1'b1, 20);
      send_byte(AB_SYNC_CHAR, 8);
      seg(1'b1, 40);
`ifdef UART_AUTOBAUD_DEGLITCH_EN
      eu = 1; ex_o = 8; ex_l = 1;
`else
      eu = 0; ex_o = exp_o; ex_l = 0;
`endif
      exp_o = ex_o;
      comp++;
      if (upd_cnt - ub != eu || err_cnt - eb != 0 || int'(o) != ex_o || int'(locked) != ex_l) begin
         fails++;
         $display("FAIL glitch: upd=%0d err=%0d o=%0d locked=%0b expected %0d 0 %0d %0d",
                  upd_cnt - ub, err_cnt - eb, o, locked, eu, ex_o, ex_l);
      end
   endtask

   task automatic test_random();
      int p, ub, eb, cand;
      int v[4];
      bit ok;
      for (int t = 0; t < 12; t++) begin
         p = int'($urandom_range(3, 40));
         for (int i = 0; i < 4; i++) v[i] = 2 * p + int'($urandom_range(0, p)) - p / 2;
         model(v[0], v[1], v[2], v[3], ok, cand);
         do_relock();
         ub = upd_cnt; eb = err_cnt;
         seg(1'b1, 40);
         send_ivs(v[0], v[1], v[2], v[3], p);
         if (ok) exp_o = cand;
         comp++;
         if (upd_cnt - ub != int'(ok) || err_cnt - eb != int'(!ok)) begin
            fails++;
            $display("FAIL random_pulses[%0d]: upd=%0d err=%0d expected %0d %0d (iv %0d %0d %0d %0d)",
                     t, upd_cnt - ub, err_cnt - eb, ok, !ok, v[0], v[1], v[2], v[3]);
         end
         comp++;
         if (int'(o) != exp_o || locked !== ok) begin
            fails++;
            $display("FAIL random_state[%0d]: o=%0d locked=%0b expected %0d %0b", t, o, locked, exp_o, ok);
         end
         if (ok) begin
            comp++;
            if (last_upd_cyc != last_fall + LAT) begin
               fails++;
               $display("FAIL random_latency[%0d]: upd at %0d expected %0d", t, last_upd_cyc, last_fall + LAT);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_relock();
      lock_at("prereset", 8);
      do_relock();
      seg(1'b1, 40);
      seg(1'b0, 8);
      seg(1'b1, 8);
      seg(1'b0, 4);
      comp++;
      if (o !== 5'd8) begin
         fails++;
         $display("FAIL async_pre: o=%0d expected 8", o);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      comp++;
      if (o !== 5'(OMIN) || locked !== 1'b0 || upd !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: o=%0d locked=%0b upd=%0b err=%0b expected %0d 0 0 0",
                  o, locked, upd, err, OMIN);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in = 1'b1;
      exp_o = OMIN;
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_lock8();
      test_jitter13();
      test_range();
      test_relock();
      test_glitch();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, fails);
      $finish;
   end

endmodule
